// File: rtl/arcade_input_pkg.sv
// Shared joystick bit map and coin shaper state encoding for the arcade input conditioner.
package arcade_input_pkg;

    localparam int JB_R      = 0;
    localparam int JB_L      = 1;
    localparam int JB_D      = 2;
    localparam int JB_U      = 3;
    localparam int JB_TRIG   = 4;
    localparam int JB_START1 = 5;
    localparam int JB_START2 = 6;
    localparam int JB_COIN   = 7;
    localparam int JB_PAUSE  = 8;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        ARM
    } coin_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_shaper.sv
// Turns a raw coin button into a fixed-length pulse followed by a lockout gap;
// the button must be seen released before another pulse can start.
module coin_shaper
    import arcade_input_pkg::*;
#(
    parameter int PULSE_CYC = 2457600,
    parameter int GAP_CYC   = 1228800
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(max2(PULSE_CYC, GAP_CYC) + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    coin_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_d;
    logic             r_low_seen;
    logic             r_pulse;
    logic             w_rise;

    // A button already held when reset lifts must be released before it can count as a press.
    assign w_rise = btn & ~r_btn_d & r_low_seen;
    assign pulse  = r_pulse;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_btn_d    <= 1'b0;
            r_low_seen <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_btn_d <= btn;
            if (!btn) begin
                r_low_seen <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PULSE;
                        r_pulse <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                PULSE: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state <= GAP;
                        r_pulse <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ARM;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ARM: begin
                    if (!btn) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Conditions hps_io joystick words into a core's input bus: upright/cocktail routing,
// per-player autofire, shaped coin pulses, start lines and a pause press pulse.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int JOY_W           = 16,
    parameter int COIN_PULSE_CYC  = 2457600,
    parameter int COIN_GAP_CYC    = 1228800,
    parameter int AUTOFIRE_FRAMES = 3
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [NUM_PLAYERS*JOY_W-1:0] joy_in,
    input  logic                         cocktail,
    input  logic [NUM_PLAYERS-1:0]       autofire_en,
    input  logic                         frame_tick,
    output logic [4*NUM_PLAYERS-1:0]     dir_out,
    output logic [NUM_PLAYERS-1:0]       trig_out,
    output logic [1:0]                   start_out,
    output logic [NUM_PLAYERS-1:0]       coin_out,
    output logic                         pause_pulse
);

    localparam int AF_W = $clog2(AUTOFIRE_FRAMES + 1);
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_FRAMES - 1);

    logic [3:0]               w_dir_any;
    logic                     w_trig_any;
    logic [1:0]               w_start_any;
    logic                     w_pause_any;
    logic [4*NUM_PLAYERS-1:0] w_dir;
    logic [NUM_PLAYERS-1:0]   w_trig_raw;
    logic [NUM_PLAYERS-1:0]   w_coin_btn;
    logic                     w_unused;

    logic [4*NUM_PLAYERS-1:0] r_dir;
    logic [NUM_PLAYERS-1:0]   r_trig;
    logic [NUM_PLAYERS-1:0]   r_af_act;
    logic [AF_W-1:0]          r_af_cnt [NUM_PLAYERS];
    logic [1:0]               r_start;
    logic                     r_pause_d;
    logic                     r_pause_pulse;

    assign w_unused = ^joy_in;

    always_comb begin
        w_dir_any   = '0;
        w_trig_any  = 1'b0;
        w_start_any = '0;
        w_pause_any = 1'b0;
        w_dir       = '0;
        w_trig_raw  = '0;
        w_coin_btn  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_dir_any   |= joy_in[p*JOY_W + JB_R +: 4];
            w_trig_any  |= joy_in[p*JOY_W + JB_TRIG];
            w_start_any |= joy_in[p*JOY_W + JB_START1 +: 2];
            w_pause_any |= joy_in[p*JOY_W + JB_PAUSE];
            w_dir[p*4 +: 4] = joy_in[p*JOY_W + JB_R +: 4];
            w_trig_raw[p]   = joy_in[p*JOY_W + JB_TRIG];
            w_coin_btn[p]   = joy_in[p*JOY_W + JB_COIN];
        end
        // Upright cabinets share one control panel, so player 0 sees everyone's stick and fire.
        if (!cocktail) begin
            w_dir[3:0]    = w_dir_any;
            w_trig_raw[0] = w_trig_any;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dir         <= '0;
            r_trig        <= '0;
            r_af_act      <= '0;
            r_start       <= '0;
            r_pause_d     <= 1'b0;
            r_pause_pulse <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_af_cnt[p] <= '0;
            end
        end else begin
            r_dir         <= w_dir;
            r_start       <= w_start_any;
            r_pause_d     <= w_pause_any;
            r_pause_pulse <= w_pause_any & ~r_pause_d;
            r_af_act      <= autofire_en & w_trig_raw;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (!(autofire_en[p] && w_trig_raw[p])) begin
                    r_trig[p]   <= w_trig_raw[p];
                    r_af_cnt[p] <= '0;
                end else if (!r_af_act[p]) begin
                    r_trig[p]   <= 1'b1;
                    r_af_cnt[p] <= '0;
                end else if (frame_tick) begin
                    if (r_af_cnt[p] == AF_LAST) begin
                        r_trig[p]   <= ~r_trig[p];
                        r_af_cnt[p] <= '0;
                    end else begin
                        r_af_cnt[p] <= r_af_cnt[p] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        coin_shaper #(
            .PULSE_CYC (COIN_PULSE_CYC),
            .GAP_CYC   (COIN_GAP_CYC)
        ) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .btn     (w_coin_btn[p]),
            .pulse   (coin_out[p])
        );
    end

    assign dir_out     = r_dir;
    assign trig_out    = r_trig;
    assign start_out   = r_start;
    assign pause_pulse = r_pause_pulse;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with short coin and autofire timings.
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [31:0] joy_in;
    logic        cocktail;
    logic [1:0]  autofire_en;
    logic        frame_tick;
    logic [7:0]  dir_out;
    logic [1:0]  trig_out;
    logic [1:0]  start_out;
    logic [1:0]  coin_out;
    logic        pause_pulse;

    int nvec  = 0;
    int nfail = 0;

    arcade_input_ctrl #(
        .NUM_PLAYERS     (2),
        .JOY_W           (16),
        .COIN_PULSE_CYC  (4),
        .COIN_GAP_CYC    (3),
        .AUTOFIRE_FRAMES (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .joy_in      (joy_in),
        .cocktail    (cocktail),
        .autofire_en (autofire_en),
        .frame_tick  (frame_tick),
        .dir_out     (dir_out),
        .trig_out    (trig_out),
        .start_out   (start_out),
        .coin_out    (coin_out),
        .pause_pulse (pause_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        joy_in      = '0;
        cocktail    = 1'b0;
        autofire_en = '0;
        frame_tick  = 1'b0;
        #23;
        nvec++;
        if ({dir_out, trig_out, start_out, coin_out, pause_pulse} !== 15'h0) begin
            nfail++;
            $display("FAIL reset_outputs: got %h want 0", {dir_out, trig_out, start_out, coin_out, pause_pulse});
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) step();
        nvec++;
        if ({dir_out, trig_out, start_out, coin_out, pause_pulse} !== 15'h0) begin
            nfail++;
            $display("FAIL idle_after_reset: got %h want 0", {dir_out, trig_out, start_out, coin_out, pause_pulse});
        end
    endtask

    task automatic test_routing();
        joy_in   = 32'h0008_0000;
        cocktail = 1'b0;
        step();
        nvec++;
        if (dir_out !== 8'h88) begin
            nfail++;
            $display("FAIL upright_dir: got %h want 88", dir_out);
        end
        cocktail = 1'b1;
        step();
        nvec++;
        if (dir_out !== 8'h80) begin
            nfail++;
            $display("FAIL cocktail_dir: got %h want 80", dir_out);
        end
        joy_in   = 32'h0010_0000;
        cocktail = 1'b0;
        step();
        nvec++;
        if (trig_out !== 2'b11) begin
            nfail++;
            $display("FAIL upright_trig: got %b want 11", trig_out);
        end
        cocktail = 1'b1;
        step();
        nvec++;
        if (trig_out !== 2'b10) begin
            nfail++;
            $display("FAIL cocktail_trig: got %b want 10", trig_out);
        end
        joy_in   = '0;
        cocktail = 1'b0;
        step();
        nvec++;
        if ({dir_out, trig_out} !== 10'h0) begin
            nfail++;
            $display("FAIL routing_clear: got %h want 0", {dir_out, trig_out});
        end
    endtask

    task automatic test_coin_shaping();
        logic e_val;
        joy_in = 32'h0000_0080;
        for (int k = 0; k < 20; k++) begin
            step();
            e_val = (k < 4);
            nvec++;
            if (coin_out[0] !== e_val) begin
                nfail++;
                $display("FAIL coin_hold cycle %0d: got %b want %b", k, coin_out[0], e_val);
            end
        end
        nvec++;
        if (coin_out[1] !== 1'b0) begin
            nfail++;
            $display("FAIL coin_other_player: got %b want 0", coin_out[1]);
        end
        joy_in = '0;
        step();
        nvec++;
        if (coin_out[0] !== 1'b0) begin
            nfail++;
            $display("FAIL coin_release: got %b want 0", coin_out[0]);
        end
        joy_in = 32'h0000_0080;
        for (int k = 0; k < 8; k++) begin
            step();
            e_val = (k < 4);
            nvec++;
            if (coin_out[0] !== e_val) begin
                nfail++;
                $display("FAIL coin_repress cycle %0d: got %b want %b", k, coin_out[0], e_val);
            end
        end
        joy_in = '0;
        repeat (6) step();
    endtask

    task automatic test_coin_lockout();
        int   rises = 0;
        int   highs = 0;
        int   second_rise = -1;
        logic prev = 1'b0;
        for (int k = 0; k < 20; k++) begin
            joy_in = (k < 16 && (k % 2) == 0) ? 32'h0000_0080 : 32'h0;
            step();
            if (coin_out[0] === 1'b1) highs++;
            if (coin_out[0] === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rises == 2) second_rise = k;
            end
            prev = coin_out[0];
        end
        nvec++;
        if (rises != 2) begin
            nfail++;
            $display("FAIL lockout_pulses: got %0d want 2", rises);
        end
        nvec++;
        if (highs != 8) begin
            nfail++;
            $display("FAIL lockout_high_cycles: got %0d want 8", highs);
        end
        nvec++;
        if (second_rise != 10) begin
            nfail++;
            $display("FAIL lockout_second_start: got %0d want 10", second_rise);
        end
        joy_in = '0;
        repeat (10) step();
    endtask

    task automatic test_autofire();
        logic e_val;
        autofire_en = 2'b01;
        for (int i = 0; i <= 80; i++) begin
            joy_in     = (i < 80) ? 32'h0000_0010 : 32'h0;
            frame_tick = (i < 80) && ((i % 10) == 5);
            step();
            e_val = (i < 15) || (i >= 35 && i < 55) || (i >= 75 && i < 80);
            nvec++;
            if (trig_out[0] !== e_val) begin
                nfail++;
                $display("FAIL autofire cycle %0d: got %b want %b", i, trig_out[0], e_val);
            end
        end
        frame_tick = 1'b0;
        step();
        joy_in = 32'h0000_0010;
        step();
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        nvec++;
        if (trig_out[0] !== 1'b0) begin
            nfail++;
            $display("FAIL autofire_fast_toggle: got %b want 0", trig_out[0]);
        end
        autofire_en = 2'b00;
        step();
        nvec++;
        if (trig_out[0] !== 1'b1) begin
            nfail++;
            $display("FAIL autofire_disable_held: got %b want 1", trig_out[0]);
        end
        joy_in = '0;
        step();
        nvec++;
        if (trig_out[0] !== 1'b0) begin
            nfail++;
            $display("FAIL autofire_disable_release: got %b want 0", trig_out[0]);
        end
    endtask

    task automatic test_pause_start();
        int pulses = 0;
        for (int k = 0; k < 12; k++) begin
            joy_in = (k < 10) ? 32'h0100_0100 : 32'h0;
            step();
            if (pause_pulse === 1'b1) pulses++;
            if (k == 0) begin
                nvec++;
                if (pause_pulse !== 1'b1) begin
                    nfail++;
                    $display("FAIL pause_first_cycle: got %b want 1", pause_pulse);
                end
            end
        end
        nvec++;
        if (pulses != 1) begin
            nfail++;
            $display("FAIL pause_count: got %0d want 1", pulses);
        end
        joy_in = 32'h0040_0000;
        step();
        nvec++;
        if (start_out !== 2'b10) begin
            nfail++;
            $display("FAIL start2_p1: got %b want 10", start_out);
        end
        joy_in = 32'h0000_0020;
        step();
        nvec++;
        if (start_out !== 2'b01) begin
            nfail++;
            $display("FAIL start1_p0: got %b want 01", start_out);
        end
        joy_in = '0;
        step();
    endtask

    task automatic test_reset_mid();
        int highs = 0;
        joy_in = 32'h0000_0080;
        step();
        step();
        nvec++;
        if (coin_out[0] !== 1'b1) begin
            nfail++;
            $display("FAIL mid_pulse_before_reset: got %b want 1", coin_out[0]);
        end
        #3;
        reset_n = 1'b0;
        #1;
        nvec++;
        if (coin_out[0] !== 1'b0) begin
            nfail++;
            $display("FAIL async_reset_drop: got %b want 0", coin_out[0]);
        end
        step();
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (coin_out[0] !== 1'b0) highs++;
        end
        nvec++;
        if (highs != 0) begin
            nfail++;
            $display("FAIL held_after_reset: got %0d high cycles want 0", highs);
        end
        joy_in = '0;
        step();
        joy_in = 32'h0000_0080;
        step();
        nvec++;
        if (coin_out[0] !== 1'b1) begin
            nfail++;
            $display("FAIL repress_after_reset: got %b want 1", coin_out[0]);
        end
        joy_in = '0;
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_routing();
        test_coin_shaping();
        test_coin_lockout();
        test_autofire();
        test_pause_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Parametrised input conditioner between hps_io joystick words and a game core's active-high input/DIP bus.
- Replaces the ad-hoc per-core joystick wiring in the top-level wrapper.
- Generalises it to NUM_PLAYERS players, with upright/cocktail routing, coin pulse shaping with lockout, per-player autofire and pause-button edge detection.
- All outputs are registered in the clk_sys domain.

Parameters:
- NUM_PLAYERS, 2: number of joystick words consumed (1..4).
- JOY_W, 16: width of each joystick word.
- COIN_PULSE_CYC, 2457600: coin_out high time in clocks (100 ms at 24.576 MHz).
- COIN_GAP_CYC, 1228800: post-pulse lockout in clocks.
- AUTOFIRE_FRAMES, 3: frame_tick pulses per autofire half-period; must be ≥1.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- joy_in  in  NUM_PLAYERS*JOY_W  player p occupies bits [p*JOY_W +: JOY_W].
  - Bit map: 0 R, 1 L, 2 D, 3 U, 4 trig, 5 start1, 6 start2, 7 coin, 8 pause.
- cocktail  in  1  0 = upright, 1 = cocktail.
- autofire_en  in  NUM_PLAYERS  per-player autofire enable.
- frame_tick  in  1  one-cycle pulse per video frame.
- dir_out  out  4*NUM_PLAYERS  {U,D,L,R} per player.
- trig_out  out  NUM_PLAYERS  conditioned trigger.
- start_out  out  2  start1/start2.
- coin_out  out  NUM_PLAYERS  shaped coin pulse.
- pause_pulse  out  1  one-cycle pulse on pause press.

Behaviour:
- Reset: every output is 0, all FSMs are in IDLE, all counters are 0, and edge-detect history is 0. Reset applies asynchronously at any time, including mid-pulse.
- Latency: one clk_sys cycle from joy_in to dir_out and start_out.
- Upright routing:
  - Player 0 dir = OR of all players' dir bits; player 0 raw trigger = OR of all triggers.
  - Players 1..N-1 outputs = their own bits.
- Cocktail routing: each player's outputs come only from its own bits.
- start_out[k] = OR over all players of bit 5+k.
- Coin shaper (one per player, on bit 7 of that player's own word, in both modes):
  - IDLE: on a coin rising edge, go to PULSE, coin_out = 1, counter = 0. Output rises on the cycle after the edge is sampled.
  - PULSE: hold coin_out = 1 for exactly COIN_PULSE_CYC cycles, then go to GAP with coin_out = 0.
  - GAP: hold coin_out = 0 for COIN_GAP_CYC cycles, then go to ARM.
  - ARM: wait for coin bit = 0, then go to IDLE. A held button never retriggers.
  - Any edge during PULSE, GAP or ARM is dropped.
- Autofire (per player, applied after routing):
  - Disabled: trig_out = raw trigger, registered.
  - Enabled, trigger held:
    - trig_out = 1 on the first registered cycle.
    - Count frame_tick pulses; at count AUTOFIRE_FRAMES, toggle trig_out and clear the count.
  - Trigger released: trig_out = 0 and the count clears on the next cycle.
  - Clearing autofire_en while held: trig_out follows raw on the next cycle and the count clears.
- Pause: pause_pulse = 1 for one cycle when the OR of all players' bit 8 rises. Holding the button gives a single pulse.
- Simultaneous events: coin edges from different players are independent, and all of them may be in PULSE at once.
- Counter widths: $clog2(max(COIN_PULSE_CYC, COIN_GAP_CYC)+1) and $clog2(AUTOFIRE_FRAMES+1). Counters never wrap.

Decomposition:
- Package arcade_input_pkg:
  - Joystick bit-index localparams: JB_R, JB_L, JB_D, JB_U, JB_TRIG, JB_START1, JB_START2, JB_COIN, JB_PAUSE.
  - Coin FSM enum coin_state_t {IDLE, PULSE, GAP, ARM}.
- One sub-module, coin_shaper:
  - Parameters PULSE_CYC and GAP_CYC; ports clk_sys, reset_n, btn, pulse.
  - Instantiated NUM_PLAYERS times by a generate loop.
- Routing and autofire stay inline.

Test Plan (bench parameters: NUM_PLAYERS=2, COIN_PULSE_CYC=4, COIN_GAP_CYC=3, AUTOFIRE_FRAMES=2):
1. Upright routing:
   - Stimulus: player 1 U (bit 3) held, cocktail = 0.
   - Expected: dir_out[3] = 1 and dir_out[7] = 1 one cycle later.
   - Then set cocktail = 1: dir_out[3] = 0 next cycle, dir_out[7] stays 1.
2. Coin shaping:
   - Stimulus: player 0 coin held for 20 cycles.
   - Expected: coin_out[0] high for exactly 4 cycles starting cycle 1, then low for the rest of the hold.
   - Re-press 1 cycle after release (past GAP): exactly one new 4-cycle pulse.
3. Coin lockout:
   - Stimulus: coin toggled every cycle for 16 cycles.
   - Expected: one pulse per full PULSE + GAP + ARM sequence; no pulse starts while in GAP.
4. Autofire:
   - Stimulus: autofire_en[0] = 1, trigger held, frame_tick every 10 cycles.
   - Expected: trig_out[0] = 1, toggles after the 2nd, 4th, 6th ticks, giving the sequence 1,0,1,0.
   - Release: trig_out[0] = 0 next cycle.
5. Pause and start:
   - Stimulus: both players press pause in the same cycle and hold 10 cycles.
   - Expected: exactly one pause_pulse.
   - Stimulus: player 1 bit 6 held. Expected: start_out = 2'b10.
6. Reset mid-operation:
   - Stimulus: assert reset_n = 0 during cycle 2 of PULSE.
   - Expected: coin_out drops immediately without a clock edge.
   - After release with coin still held: no pulse until the button is released and pressed again.
